jacobi_sweep_controller: RTL

Sequences the Jacobi eigen-decomposition loop of the PCA accelerator. It captures each covariance matrix produced by the TPU, scans it serially for the largest off-diagonal element, and hands the rotation pivot (p, q, c_pq, c_pp, c_qq) to the CORDIC engine over a valid/ready handshake. It then waits for the rotation to be applied and repeats until the matrix converges or the iteration budget runs out.

---
 rtl/jacobi_sweep_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jacobi_sweep_controller.sv
// Jacobi sweep controller: captures a 4x4 covariance matrix, serially scans it
// for the largest off-diagonal element, hands the rotation pivot to the CORDIC
// engine and loops until convergence or until the rotation budget is spent.
module jacobi_sweep_controller #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_SIZE   = 8,
  parameter int MAX_ITER    = 16,
  parameter int THRESHOLD   = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          matrix_valid,
  input  logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_from_TPU,
  output logic                                          cordic_valid,
  input  logic                                          cordic_ready,
  input  logic                                          rot_done,
  output logic [1:0]                                    p,
  output logic [1:0]                                    q,
  output logic [DATA_SIZE-1:0]                          c_pq,
  output logic [DATA_SIZE-1:0]                          c_pp,
  output logic [DATA_SIZE-1:0]                          c_qq,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          converged,
  output logic [7:0]                                    iter_count
);

  localparam int NELEM = MATRIX_SIZE * MATRIX_SIZE;

  typedef enum logic [2:0] {
    IDLE, WAIT_MAT, SCAN, CHECK, ISSUE, WAIT_ROT, FINISH
  } state_t;

  state_t state, next_state;

  logic [NELEM-1:0][DATA_SIZE-1:0] mat;
  logic [3:0]                      idx;
  logic [DATA_SIZE-1:0]            best;
  logic [1:0]                      bp, bq;

  // Row/column of the element under scan; index layout is row-major 4x4.
  logic [1:0]           row, col;
  logic [DATA_SIZE-1:0] elem;
  logic                 below_thr;
  logic                 budget_out;

  assign row        = idx[3:2];
  assign col        = idx[1:0];
  assign elem       = mat[idx];
  assign below_thr  = 32'(best) < 32'(THRESHOLD);
  assign budget_out = iter_count == 8'(MAX_ITER);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; handshake/status outputs decode the registered state only.
  always_comb begin
    next_state   = state;
    cordic_valid = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = WAIT_MAT;
      end
      WAIT_MAT: if (matrix_valid) next_state = SCAN;
      SCAN:     if (idx == 4'd15) next_state = CHECK;
      CHECK: begin
        if (below_thr || budget_out) next_state = FINISH;
        else                         next_state = ISSUE;
      end
      ISSUE: begin
        cordic_valid = 1'b1;
        if (cordic_ready) next_state = WAIT_ROT;
      end
      WAIT_ROT: if (rot_done) next_state = WAIT_MAT;
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: matrix capture, serial max search, pivot/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mat        <= '0;
      idx        <= '0;
      best       <= '0;
      bp         <= 2'd0;
      bq         <= 2'd1;
      p          <= '0;
      q          <= '0;
      c_pq       <= '0;
      c_pp       <= '0;
      c_qq       <= '0;
      converged  <= 1'b0;
      iter_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          iter_count <= '0;
          converged  <= 1'b0;
        end
        WAIT_MAT: if (matrix_valid) begin
          mat  <= data_from_TPU;
          idx  <= '0;
          best <= '0;
          bp   <= 2'd0;
          bq   <= 2'd1;
        end
        SCAN: begin
          // Strict compare keeps the earliest index on ties.
          if (row != col && elem > best) begin
            best <= elem;
            bp   <= row;
            bq   <= col;
          end
          idx <= idx + 4'd1;
        end
        CHECK: begin
          p    <= bp;
          q    <= bq;
          c_pq <= best;
          c_pp <= mat[{bp, bp}];
          c_qq <= mat[{bq, bq}];
          if (below_thr) converged <= 1'b1;
        end
        ISSUE: if (cordic_ready) iter_count <= iter_count + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
